// File: rtl/rr_sel_arb_4ch.sv
// 4-channel round-robin arbiter that drives the select lines of a 4:1 mux.
// A per-channel hold limit stops one requester from starving the others.
module rr_sel_arb_4ch #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_i,
  input  logic       done_i,
  output logic [3:0] gnt_o,
  output logic       s0_o,
  output logic       s1_o,
  output logic       valid_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  // Returns {found, index} for the first set mask bit, searching from ptr+1 and wrapping.
  function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!res[2] && mask[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       valid_q, valid_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] hold_q, hold_d;

  logic [3:0] others_s;
  logic [2:0] idle_win_s;
  logic [2:0] bb_win_s;
  logic       release_s;

  // The releasing channel is masked out of the back-to-back search.
  assign others_s   = req_i & ~gnt_q;
  assign idle_win_s = rr_pick(req_i, ptr_q);
  assign bb_win_s   = rr_pick(others_s, ptr_q);
  assign release_s  = done_i | ~|(req_i & gnt_q) | ((hold_q == HOLD_LAST) & |others_s);

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (idle_win_s[2]) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << idle_win_s[1:0];
          sel_d   = idle_win_s[1:0];
          valid_d = 1'b1;
          ptr_d   = idle_win_s[1:0];
          hold_d  = 8'd0;
        end else begin
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (release_s) begin
          if (bb_win_s[2]) begin
            state_d = GRANT;
            gnt_d   = 4'b0001 << bb_win_s[1:0];
            sel_d   = bb_win_s[1:0];
            valid_d = 1'b1;
            ptr_d   = bb_win_s[1:0];
            hold_d  = 8'd0;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
            hold_d  = 8'd0;
          end
        end else if (hold_q == HOLD_LAST) begin
          hold_d = hold_q;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
        hold_d  = 8'd0;
      end
    endcase
  end

  // State and output registers; ptr resets to 3 so the first search starts at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      valid_q <= 1'b0;
      ptr_q   <= 2'd3;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign s0_o    = sel_q[0];
  assign s1_o    = sel_q[1];
  assign valid_o = valid_q;

endmodule

// Output consistency checker: grant one-hot or zero, valid tracks the grant, select matches it.
module rr_sel_arb_4ch_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [3:0] gnt_i,
  input logic       s0_i,
  input logic       s1_i,
  input logic       valid_i
);

  logic [1:0] gnt_idx_s;
  assign gnt_idx_s = {gnt_i[2] | gnt_i[3], gnt_i[1] | gnt_i[3]};

  // Sampled on the falling edge, away from output updates.
  always @(negedge clk) begin
    if (rst_n) begin
      a_onehot0: assert ($onehot0(gnt_i)) else $error("chk gnt not one-hot/zero: %b", gnt_i);
      a_valid:   assert (valid_i == |gnt_i) else $error("chk valid=%b gnt=%b", valid_i, gnt_i);
      a_sel:     assert (!valid_i || ({s1_i, s0_i} == gnt_idx_s))
                   else $error("chk sel=%b%b gnt=%b", s1_i, s0_i, gnt_i);
    end
  end

endmodule

// File: tb/tb_rr_sel_arb_4ch.sv
// Scoreboard bench for rr_sel_arb_4ch: a channel-level reference model pushes the
// expected outputs per cycle, and a monitor compares them after every rising edge.
module tb_rr_sel_arb_4ch;

  localparam int HOLD = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req   = 4'b0000;
  logic       done  = 1'b0;
  logic [3:0] gnt;
  logic       s0, s1, valid;

  rr_sel_arb_4ch #(.HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .done_i(done),
    .gnt_o(gnt), .s0_o(s0), .s1_o(s1), .valid_o(valid)
  );

  rr_sel_arb_4ch_chk u_chk (
    .clk(clk), .rst_n(rst_n), .gnt_i(gnt), .s0_i(s0), .s1_i(s1), .valid_i(valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: which channel owns the mux, who was granted last, and for how long.
  int cur    = -1;
  int last   = 3;
  int sel_m  = 0;
  int cycles = 0;

  function automatic int pick(input logic [3:0] mask, input int from);
    for (int k = 1; k <= 4; k++) begin
      if (mask[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_and_push();
    logic [3:0] others;
    bit         rel;
    exp_t       e;
    if (cur < 0) begin
      if (req != 4'b0000) begin
        cur = pick(req, last); last = cur; sel_m = cur; cycles = 1;
      end
    end else begin
      others = req & ~(4'b0001 << cur);
      rel = done || !req[cur] || (cycles >= HOLD && others != 4'b0000);
      if (rel) begin
        if (others != 4'b0000) begin
          cur = pick(others, last); last = cur; sel_m = cur; cycles = 1;
        end else begin
          cur = -1;
        end
      end else begin
        cycles++;
      end
    end
    e.gnt   = (cur < 0) ? 4'b0000 : (4'b0001 << cur);
    e.sel   = sel_m[1:0];
    e.valid = (cur >= 0);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [3:0] r, input logic d);
    @(negedge clk);
    req  = r;
    done = d;
    model_and_push();
  endtask

  task automatic async_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, s1, s0, valid} !== 7'b0) begin
      errors++;
      $display("FAIL async_reset gnt=%b s1s0=%b%b valid=%b required all zero", gnt, s1, s0, valid);
    end
    cur = -1; last = 3; sel_m = 0; cycles = 0;
    exp_q.delete();
    req  = 4'b0000;
    done = 1'b0;
    #1 rst_n = 1'b1;
    model_and_push();
  endtask

  // Monitor: pops one expectation per rising edge and compares all outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({gnt, s1, s0, valid} !== {e.gnt, e.sel, e.valid}) begin
          errors++;
          $display("FAIL outputs t=%0t gnt=%b s1s0=%b%b valid=%b required gnt=%b s1s0=%b valid=%b",
                   $time, gnt, s1, s0, valid, e.gnt, e.sel, e.valid);
        end
      end
    end
  end

  initial begin
    logic [3:0] r;
    logic       d;
    #1 rst_n = 1'b0;
    async_reset();

    // Full rotation driven by done pulses.
    step(4'b1111, 1'b0);
    repeat (6) step(4'b1111, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // Lone requester saturates without release.
    repeat (20) step(4'b0100, 1'b0);

    // Two requesters alternate at the hold limit.
    repeat (40) step(4'b0011, 1'b0);

    // Drop to idle, then the same channel wins again.
    step(4'b0100, 1'b1);
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);

    // done and req[granted] falling together.
    step(4'b0110, 1'b0);
    step(4'b0010, 1'b1);
    step(4'b0010, 1'b0);

    // Reset in the middle of a channel 3 grant.
    step(4'b0000, 1'b0);
    repeat (3) step(4'b1000, 1'b0);
    async_reset();
    repeat (3) step(4'b1000, 1'b0);

    // Randomized traffic with sticky request patterns.
    r = 4'b0000;
    repeat (3000) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      d = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 799) == 0) async_reset();
      step(r, d);
    end

    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
